// File: rtl/count_seq_ctrl_if.sv
// Command channel for count_seq_ctrl: a valid/ready handshake that carries
// one counting command (start, stop, direction, number of passes).
interface count_seq_ctrl_if #(
  parameter int CNT_W = 4,
  parameter int REP_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_start;
  logic [CNT_W-1:0] cmd_stop;
  logic             cmd_dir;
  logic [REP_W-1:0] cmd_reps;

  // Issuer of commands.
  modport master (
    output cmd_valid,
    output cmd_start,
    output cmd_stop,
    output cmd_dir,
    output cmd_reps,
    input  cmd_ready
  );

  // The counter controller.
  modport slave (
    input  cmd_valid,
    input  cmd_start,
    input  cmd_stop,
    input  cmd_dir,
    input  cmd_reps,
    output cmd_ready
  );
endinterface

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: command-driven up/down counter sequencer.
// A command counts from start to stop (modulo 2^CNT_W) for a number of
// passes, with hold/abort control and wrap/pass/done pulses. All outputs
// are registered.
// Optional feature: define COUNT_SEQ_PINGPONG_EN to make successive passes
// alternate direction (start/stop swapped) instead of reloading start.
module count_seq_ctrl #(
  parameter int CNT_W = 4,
  parameter int REP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  count_seq_ctrl_if.slave   cmd,
  input  logic              hold,
  input  logic              abort,
  output logic [CNT_W-1:0]  cnt_q,
  output logic              busy,
  output logic              wrap,
  output logic              pass_done,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_start;
  logic [CNT_W-1:0] w_start_nxt;
  logic [CNT_W-1:0] r_stop;
  logic [CNT_W-1:0] w_stop_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic [REP_W-1:0] r_reps_left;
  logic [REP_W-1:0] w_reps_nxt;

  logic             r_busy;
  logic             r_cmd_ready;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             r_pass_done;
  logic             w_pass_done_nxt;
  logic             r_done;
  logic             w_done_nxt;

  logic             w_accept;
  logic [CNT_W-1:0] w_step;
  logic             w_at_boundary;
  logic             w_at_stop;
  logic             w_last_pass;

  assign w_accept      = cmd.cmd_valid & r_cmd_ready;
  assign w_step        = r_dir ? (r_cnt - CNT_W'(1)) : (r_cnt + CNT_W'(1));
  // Stepping from the boundary value crosses the modulo wrap point.
  assign w_at_boundary = r_dir ? (r_cnt == '0) : (r_cnt == '1);
  assign w_at_stop     = (r_cnt == r_stop);
  assign w_last_pass   = (r_reps_left == REP_W'(1));

  // Next-state, next-count and pulse generation.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_start_nxt     = r_start;
    w_stop_nxt      = r_stop;
    w_dir_nxt       = r_dir;
    w_reps_nxt      = r_reps_left;
    w_wrap_nxt      = 1'b0;
    w_pass_done_nxt = 1'b0;
    w_done_nxt      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_start_nxt = cmd.cmd_start;
          w_stop_nxt  = cmd.cmd_stop;
          w_dir_nxt   = cmd.cmd_dir;
          // A repeat count of zero still runs one pass.
          w_reps_nxt  = (cmd.cmd_reps == '0) ? REP_W'(1) : cmd.cmd_reps;
          w_state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = r_start;
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (!hold) begin
          if (!w_at_stop) begin
            w_cnt_nxt  = w_step;
            w_wrap_nxt = w_at_boundary;
          end else begin
            w_pass_done_nxt = 1'b1;
            w_reps_nxt      = r_reps_left - REP_W'(1);
            if (w_last_pass) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end else begin
`ifdef COUNT_SEQ_PINGPONG_EN
              // Count stays on the old stop; the reversed pass steps away
              // from it on the next RUN cycle.
              w_start_nxt = r_stop;
              w_stop_nxt  = r_start;
              w_dir_nxt   = ~r_dir;
`else
              w_cnt_nxt   = r_start;
`endif
            end
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, latched command and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_start     <= '0;
      r_stop      <= '0;
      r_dir       <= 1'b0;
      r_reps_left <= '0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_wrap      <= 1'b0;
      r_pass_done <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_start     <= w_start_nxt;
      r_stop      <= w_stop_nxt;
      r_dir       <= w_dir_nxt;
      r_reps_left <= w_reps_nxt;
      // Status flags track the state being entered so they are flop outputs.
      r_busy      <= (w_state_nxt != S_IDLE);
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_wrap      <= w_wrap_nxt;
      r_pass_done <= w_pass_done_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign cnt_q         = r_cnt;
  assign busy          = r_busy;
  assign wrap          = r_wrap;
  assign pass_done     = r_pass_done;
  assign done          = r_done;
  assign cmd.cmd_ready = r_cmd_ready;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench for count_seq_ctrl. Each command is expanded by a
// list-based reference model into the per-cycle observations expected
// while the controller is busy; a monitor pops and compares them.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold;
  logic       abort;
  logic [3:0] cnt_q;
  logic       busy;
  logic       wrap;
  logic       pass_done;
  logic       done;

  always #5 clk = ~clk;

  count_seq_ctrl_if #(.CNT_W(4), .REP_W(4)) cif ();

  count_seq_ctrl #(.CNT_W(4), .REP_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cif.slave),
    .hold      (hold),
    .abort     (abort),
    .cnt_q     (cnt_q),
    .busy      (busy),
    .wrap      (wrap),
    .pass_done (pass_done),
    .done      (done)
  );

  typedef struct packed {
    logic [3:0] cnt;
    logic       wr;
    logic       pd;
    logic       dn;
    logic       bsy;
    logic       rdy;
  } obs_t;

  typedef struct {
    logic [3:0] v;
    bit         w;
    bit         last;
  } el_t;

  obs_t       sb[$];
  int         n_pass  = 0;
  int         n_total = 0;
  bit         prev_busy = 1'b0;
  bit         hold_sched[0:1023];
  logic [3:0] m_cnt = 4'd0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic obs_t mk(input logic [3:0] c, input logic w, input logic p,
                              input logic d, input logic b);
    obs_t o;
    o.cnt = c; o.wr = w; o.pd = p; o.dn = d; o.bsy = b; o.rdy = ~b;
    return o;
  endfunction

  // Monitor: compares every busy cycle plus the first idle cycle after it.
  always @(negedge clk) begin
    obs_t act;
    obs_t e;
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      act = mk(cnt_q, wrap, pass_done, done, busy);
      act.rdy = cif.cmd_ready;
      if (busy || prev_busy) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("obs{cnt,wrap,pd,done,busy,ready}", int'(act), int'(e));
        end
      end else begin
        check("idle_flags{wrap,pd,done,busy,ready}",
              int'({wrap, pass_done, done, busy, cif.cmd_ready}), 5'b00001);
      end
      prev_busy = busy;
    end
  end

  // Issue one command; expected observations are derived from the pass
  // value lists and pushed before driving. Called mid-cycle with DUT idle.
  task automatic run_cmd(input logic [3:0] st, input logic [3:0] sp, input logic d,
                         input logic [3:0] rp, input int hold_pct, input int hold_from,
                         input int hold_len, input int abort_at, input int rst_at);
    el_t        el[$];
    obs_t       q[$];
    logic [3:0] s, e, diff, v, cur;
    logic       dr;
    int         passes, len, i, k, last_cycle;
    el_t        x;

    for (int c = 0; c < 1024; c++)
      hold_sched[c] = ((c >= hold_from) && (c < hold_from + hold_len)) ||
                      ($urandom_range(99) < hold_pct);

    // Concatenated count values of every pass.
    passes = (rp == 4'd0) ? 1 : int'(rp);
    s = st; e = sp; dr = d;
    for (int p = 0; p < passes; p++) begin
      diff = dr ? (s - e) : (e - s);
      len  = int'(diff) + 1;
      for (int j = 0; j < len; j++) begin
        v = dr ? (s - 4'(j)) : (s + 4'(j));
        x.v = v;
        x.w = (j > 0) && (dr ? (v == 4'hF) : (v == 4'h0));
        x.last = (j == len - 1);
        el.push_back(x);
      end
`ifdef COUNT_SEQ_PINGPONG_EN
      v = s; s = e; e = v; dr = ~dr;
`endif
    end

    // Cycle-by-cycle expectations, cycle 1 being the one after acceptance.
    q.push_back(mk(m_cnt, 0, 0, 0, 1));
    cur = m_cnt;
    if (abort_at == 1) begin
      q.push_back(mk(m_cnt, 0, 0, 0, 0));
    end else begin
      i = 0;
      cur = el[0].v;
      q.push_back(mk(cur, el[0].w, 0, 0, 1));
      k = 2;
      while (k < 1000) begin
        if (k == abort_at) begin
          q.push_back(mk(cur, 0, 0, 0, 0));
          break;
        end
        if (hold_sched[k]) begin
          q.push_back(mk(cur, 0, 0, 0, 1));
          k++;
          continue;
        end
        if (i == el.size() - 1) begin
          q.push_back(mk(cur, 0, 1, 1, 1));
          q.push_back(mk(cur, 0, 0, 0, 0));
          break;
        end
        i++;
        cur = el[i].v;
        q.push_back(mk(cur, el[i].w, el[i-1].last, 0, 1));
        k++;
      end
    end
    last_cycle = q.size();
    for (int c = 1; c <= last_cycle; c++)
      if (rst_at == 0 || c < rst_at) sb.push_back(q[c-1]);

    cif.cmd_valid = 1'b1;
    cif.cmd_start = st;
    cif.cmd_stop  = sp;
    cif.cmd_dir   = d;
    cif.cmd_reps  = rp;
    hold  = 1'b0;
    abort = 1'b0;
    @(posedge clk); #1;

    for (int c = 1; c < last_cycle; c++) begin
      if (c == rst_at) begin
        rst_n = 1'b0;
        cif.cmd_valid = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
        #1;
        check("rst_outputs{cnt,wrap,pd,done,busy,ready}",
              int'({cnt_q, wrap, pass_done, done, busy, cif.cmd_ready}), 9'b0000_00001);
        check("rst_sb_drained", sb.size(), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        m_cnt = 4'd0;
        return;
      end
      hold  = hold_sched[c];
      abort = (c == abort_at);
      // Commands offered while busy must be ignored.
      cif.cmd_valid = 1'($urandom_range(1));
      cif.cmd_start = 4'($urandom);
      cif.cmd_stop  = 4'($urandom);
      cif.cmd_dir   = 1'($urandom_range(1));
      cif.cmd_reps  = 4'($urandom);
      @(posedge clk); #1;
    end
    cif.cmd_valid = 1'b0;
    hold  = 1'($urandom_range(1));
    abort = 1'($urandom_range(1));
    m_cnt = cur;
  endtask

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_start = '0;
    cif.cmd_stop  = '0;
    cif.cmd_dir   = 1'b0;
    cif.cmd_reps  = '0;
    hold  = 1'b0;
    abort = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state{cnt,wrap,pd,done,busy,ready}",
          int'({cnt_q, wrap, pass_done, done, busy, cif.cmd_ready}), 9'b0000_00001);
    rst_n = 1'b1;
    #1;

    // Accepted on the first edge after reset release.
    run_cmd(4'd2,  4'd5,  1'b0, 4'd1, 0, 0, 0, 0, 0);
    run_cmd(4'd14, 4'd1,  1'b0, 4'd1, 0, 0, 0, 0, 0);
    run_cmd(4'd1,  4'd14, 1'b1, 4'd1, 0, 0, 0, 0, 0);
    run_cmd(4'd3,  4'd5,  1'b0, 4'd3, 0, 0, 0, 0, 0);
    run_cmd(4'd0,  4'd9,  1'b0, 4'd1, 0, 6, 4, 0, 0);
    run_cmd(4'd0,  4'd9,  1'b0, 4'd1, 0, 0, 0, 8, 0);
    run_cmd(4'd7,  4'd7,  1'b0, 4'd0, 0, 0, 0, 0, 0);
    run_cmd(4'd0,  4'd15, 1'b0, 4'd2, 0, 0, 0, 0, 0);
    run_cmd(4'd9,  4'd9,  1'b1, 4'd3, 30, 0, 0, 0, 0);
    run_cmd(4'd0,  4'd9,  1'b0, 4'd1, 0, 0, 0, 0, 6);
    run_cmd(4'd4,  4'd6,  1'b1, 4'd2, 0, 0, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      int ab;
      ab = ($urandom_range(5) == 0) ? int'($urandom_range(1, 20)) : 0;
      run_cmd(4'($urandom), 4'($urandom), 1'($urandom_range(1)),
              4'($urandom_range(0, 3)), ($urandom_range(1) == 1) ? 20 : 0,
              0, 0, ab, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      cif.cmd_valid = 1'b0;
    end

    hold  = 1'b0;
    abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sb_empty_at_end", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
